// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and helpers for the external SRAM controller.
//   sram_state_t   - controller FSM states
//   wait_cnt_width - width of the wait-state counter for a given timing setup
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrSetup,
        StWrPulse,
        StWrHold
    } sram_state_t;

    // Wide enough to hold the largest wait count plus headroom; never wraps.
    function automatic int unsigned wait_cnt_width(input int unsigned read_wait,
                                                   input int unsigned write_wait);
        int unsigned max_wait;
        max_wait = (read_wait > write_wait) ? read_wait : write_wait;
        return $clog2(max_wait + 2);
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-request controller between the internal memory bus and one
// asynchronous external SRAM bank, with configurable read/write wait states and
// byte-lane writes.
//
// Ports:
//   clk_50M, reset_btn       - clock, synchronous active-high reset
//   req_valid/req_ready      - request handshake (ready only when idle)
//   req_we, req_addr,        - request: write flag, word address,
//   req_be, req_wdata          byte enables (writes only), write data
//   resp_valid, resp_rdata   - one-cycle completion strobe, last read data
//   sram_addr, sram_ce_n,    - registered SRAM address and active-low strobes
//   sram_oe_n, sram_we_n,
//   sram_be_n
//   sram_data                - bidirectional data bus, driven only while writing
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned READ_WAIT  = 1,
    parameter int unsigned WRITE_WAIT = 1,
    localparam int unsigned BE_W      = DATA_W / 8
) (
    input  logic              clk_50M,
    input  logic              reset_btn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BE_W-1:0]   req_be,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [BE_W-1:0]   sram_be_n,
    inout  wire  [DATA_W-1:0] sram_data
);

    localparam int unsigned CNT_W = wait_cnt_width(READ_WAIT, WRITE_WAIT);
    localparam logic [CNT_W-1:0] READ_CNT  = CNT_W'(READ_WAIT);
    localparam logic [CNT_W-1:0] WRITE_CNT = CNT_W'(WRITE_WAIT);

    sram_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic [BE_W-1:0]   be_n_q, be_n_d;
    logic              data_oe_q, data_oe_d;
    logic              accept;

    assign accept = req_valid && (state_q == StIdle);

    // Next-state, request latching and response generation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d = req_addr;
                    if (!req_we) begin
                        state_d = StRead;
                        cnt_d   = READ_CNT;
                    end else if (req_be != '0) begin
                        state_d = StWrSetup;
                        wdata_d = req_wdata;
                        be_d    = req_be;
                    end else begin
                        // No lanes enabled: acknowledge without touching the SRAM.
                        resp_valid_d = 1'b1;
                    end
                end
            end
            StRead: begin
                if (cnt_q == '0) begin
                    state_d      = StIdle;
                    rdata_d      = sram_data;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrSetup: begin
                state_d = StWrPulse;
                cnt_d   = WRITE_CNT;
            end
            StWrPulse: begin
                if (cnt_q == '0) begin
                    state_d      = StWrHold;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // SRAM strobes are decoded from the next state so they leave a register
    // aligned with the state they belong to.
    always_comb begin
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        be_n_d    = '1;
        data_oe_d = 1'b0;

        case (state_d)
            StRead: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = '0;
            end
            StWrSetup, StWrHold: begin
                ce_n_d    = 1'b0;
                be_n_d    = ~be_d;
                data_oe_d = 1'b1;
            end
            StWrPulse: begin
                ce_n_d    = 1'b0;
                we_n_d    = 1'b0;
                be_n_d    = ~be_d;
                data_oe_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            be_n_q       <= '1;
            data_oe_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            be_n_q       <= be_n_d;
            data_oe_q    <= data_oe_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign sram_addr  = addr_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_be_n  = be_n_q;
    assign sram_data  = data_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule
